// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types and constants.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [9:0] PORT0_ADDR   = 10'h3F4;
  localparam logic [9:0] PORT1_ADDR   = 10'h3F8;
  localparam logic [9:0] OUTPORT_ADDR = 10'h3FC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way winner select for mem_arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN makes requester 0 win ties.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic     rr_last,
`endif
  output req_idx_t win
);

  // tie goes to the requester that did not win last time
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~rr_last;
`endif
    end else if (req1) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single-ported Memory_Unit.
// Build option: MEM_ARB_FIXED_PRIO_EN removes round-robin state.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_en,
  output logic                  mem_read,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  state_t                  state_q, state_d;
  req_idx_t                win_q, win_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  req_idx_t                pick;

`ifndef MEM_ARB_FIXED_PRIO_EN
  req_idx_t                rr_last_q, rr_last_d;
`endif

  mem_arb_rr_pick u_pick (
    .req0    (req0),
    .req1    (req1),
`ifndef MEM_ARB_FIXED_PRIO_EN
    .rr_last (rr_last_q),
`endif
    .win     (pick)
  );

  // state and latched command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  // next state, command latch and output decode
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_last_d    = rr_last_q;
`endif
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    rvalid0      = 1'b0;
    rvalid1      = 1'b0;
    rdata        = '0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    mem_data_in  = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_last_d = pick;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr     = addr_q;
        mem_data_in  = wdata_q;
        mem_write_en = we_q;
        mem_read     = ~we_q;
        gnt0         = ~win_q;
        gnt1         = win_q;
        state_d      = we_q ? IDLE : RDATA;
      end
      RDATA: begin
        rdata   = mem_data_out;
        rvalid0 = ~win_q;
        rvalid1 = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a Memory_Unit model.
// Build option: MEM_ARB_FIXED_PRIO_EN changes the tie tests.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [9:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, mem_data_in, mem_data_out;
  logic [9:0]  mem_addr;
  logic        mem_write_en, mem_read, busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory_Unit model: sync write, registered read output
  logic [31:0] mem [1024];
  bit          written [1024];
  bit   [31:0] mem_dout;
  bit   [31:0] out_port;

  function automatic logic [31:0] preset(input logic [9:0] a);
    case (a)
      10'h040: return 32'h22222222;
      10'h080: return 32'h33333333;
      10'h0C0: return 32'h44444444;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr]     <= mem_data_in;
      written[mem_addr] <= 1'b1;
      if (mem_addr == OUTPORT_ADDR) out_port <= mem_data_in;
    end
    if (mem_read)
      mem_dout <= written[mem_addr] ? mem[mem_addr] : preset(mem_addr);
  end
  assign mem_data_out = mem_dout;

  a_excl: assert property (@(posedge clk) !(mem_write_en && mem_read));

  always @(negedge clk) begin
    if (mem_write_en && mem_read) begin
      errors++;
      $display("FAIL excl_we_rd act=11 exp=not both");
    end
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL excl_gnt act=11 exp=not both");
    end
    if (rvalid0 && rvalid1) begin
      errors++;
      $display("FAIL excl_rvalid act=11 exp=not both");
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] all_out();
    return {47'd0, gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr,
            mem_write_en, mem_read, mem_data_in, busy};
  endfunction

  typedef struct {
    logic r0, r1, w0, w1;
    logic [9:0] a0, a1;
    logic [31:0] d0, d1;
    logic g0, g1, v0, v1;
    logic [31:0] rd;
    logic we, rdn;
    logic [9:0] ma;
    logic [31:0] md;
    logic bz;
    logic [31:0] port;
  } vec_t;

  vec_t vq[$];
  localparam logic [31:0] AB = 32'hAABBCCDD;

  initial begin
    int n0, n1, cyc;
    bit seen;
    // reset state
    #2;
    chk("reset_outputs", all_out(), '0);
    @(negedge clk);
    chk("reset_outputs_hold", all_out(), '0);
    rst_n = 1'b1;
    step();
    chk("idle_no_req", all_out(), '0);

    // r0 r1 w0 w1 a0 a1 d0 d1 | g0 g1 v0 v1 rd we rdn ma md bz port
    vq.push_back('{1,0,1,0,10'h010,0,32'h11111111,0,
                   1,0,0,0,0,1,0,10'h010,32'h11111111,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0});
    vq.push_back('{1,0,0,0,10'h010,0,0,0,
                   1,0,0,0,0,0,1,10'h010,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,
                   0,0,1,0,32'h11111111,0,0,0,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0});
    vq.push_back('{0,1,0,1,0,OUTPORT_ADDR,0,AB,
                   0,1,0,0,0,1,0,OUTPORT_ADDR,AB,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,AB});
`ifndef MEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 2; k++) begin
      vq.push_back('{1,1,0,0,10'h040,10'h080,0,0,
                     1,0,0,0,0,0,1,10'h040,0,1,AB});
      vq.push_back('{1,1,0,0,10'h040,10'h080,0,0,
                     0,0,1,0,32'h22222222,0,0,0,0,1,AB});
      vq.push_back('{1,1,0,0,10'h040,10'h080,0,0,
                     0,0,0,0,0,0,0,0,0,0,AB});
      vq.push_back('{1,1,0,0,10'h040,10'h080,0,0,
                     0,1,0,0,0,0,1,10'h080,0,1,AB});
      vq.push_back('{0,0,0,0,0,0,0,0,
                     0,0,0,1,32'h33333333,0,0,0,0,1,AB});
      vq.push_back('{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,AB});
    end
`endif

    foreach (vq[i]) begin
      req0 = vq[i].r0; req1 = vq[i].r1;
      we0 = vq[i].w0; we1 = vq[i].w1;
      addr0 = vq[i].a0; addr1 = vq[i].a1;
      wdata0 = vq[i].d0; wdata1 = vq[i].d1;
      step();
      chk($sformatf("row%0d gnt", i), {gnt0, gnt1},
          {vq[i].g0, vq[i].g1});
      chk($sformatf("row%0d rvalid", i), {rvalid0, rvalid1},
          {vq[i].v0, vq[i].v1});
      chk($sformatf("row%0d rdata", i), rdata, vq[i].rd);
      chk($sformatf("row%0d strobes", i), {mem_write_en, mem_read},
          {vq[i].we, vq[i].rdn});
      chk($sformatf("row%0d mem_addr", i), mem_addr, vq[i].ma);
      chk($sformatf("row%0d mem_data_in", i), mem_data_in, vq[i].md);
      chk($sformatf("row%0d busy", i), busy, vq[i].bz);
      chk($sformatf("row%0d out_port", i), out_port, vq[i].port);
    end

    // reset during RDATA aborts the read
    req0 = 1; we0 = 0; addr0 = 10'h0C0;
    step();
    chk("rst_gnt0", {gnt0, mem_read}, 2'b11);
    req0 = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", all_out(), '0);
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rvalid0) seen = 1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rvalid0) seen = 1;
    end
    chk("rst_no_rvalid", seen, 1'b0);
    chk("rst_after_outputs", all_out(), '0);
    chk("rst_after_state", dut.state_q, IDLE);

    // tie behaviour over six grants
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    addr0 = 10'h100; addr1 = 10'h104;
    wdata0 = 32'h0A0A0A0A; wdata1 = 32'h0B0B0B0B;
    n0 = 0; n1 = 0; cyc = 0;
    while ((n0 + n1) < 6 && cyc < 40) begin
      step();
      cyc++;
      if (gnt0) n0++;
      if (gnt1) n1++;
    end
    req0 = 0; req1 = 0;
    chk("tie_bound", cyc < 40, 1'b1);
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("tie_counts", {n0[7:0], n1[7:0]}, {8'd6, 8'd0});
`else
    chk("tie_counts", {n0[7:0], n1[7:0]}, {8'd3, 8'd3});
`endif
    step();
    chk("tie_idle", busy, 1'b0);

    // back-to-back: req1 arrives while req0's write is in ISSUE
    req0 = 1; we0 = 1; addr0 = 10'h000; wdata0 = 32'h12345678;
    step();
    chk("b2b_gnt0", {gnt0, gnt1, mem_write_en}, 3'b101);
    chk("b2b_wr_addr", {mem_addr, mem_data_in},
        {10'h000, 32'h12345678});
    req0 = 0; req1 = 1; we1 = 0; addr1 = 10'h000;
    step();
    chk("b2b_gap", {gnt0, gnt1, busy}, 3'b000);
    step();
    chk("b2b_gnt1", {gnt0, gnt1, mem_read}, 3'b011);
    req1 = 0;
    step();
    chk("b2b_rvalid1", {rvalid0, rvalid1}, 2'b01);
    chk("b2b_rdata", rdata, 32'h12345678);
    step();
    chk("b2b_idle", all_out(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-ported Memory_Unit (RAM plus memory-mapped I/O) between the CPU data port (requester 0) and the boot loader/debug port (requester 1).
- Latches one request at a time and drives the Memory_Unit command signals from registers.
- Tracks the Memory_Unit's one-cycle read latency and returns read data to the winning requester with a valid pulse.
- Uses round-robin fairness; I/O addresses 0x3F4/0x3F8/0x3FC pass through untouched.

Parameters:
- ADDR_WIDTH, 10, word address width, matches Memory_Unit.
- DATA_WIDTH, 32, data width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req0, req1  in  1  access request per requester
- we0, we1  in  1  1=write, 0=read
- addr0, addr1  in  ADDR_WIDTH  request address
- wdata0, wdata1  in  DATA_WIDTH  write data
- gnt0, gnt1  out  1  one-cycle pulse: command issued to memory
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata valid
- rdata  out  DATA_WIDTH  read data, shared by both requesters, qualified by rvalidN
- mem_addr  out  ADDR_WIDTH  to Memory_Unit addr
- mem_write_en  out  1  to Memory_Unit write_en
- mem_read  out  1  to Memory_Unit mem_read
- mem_data_in  out  DATA_WIDTH  to Memory_Unit data_in
- mem_data_out  in  DATA_WIDTH  from Memory_Unit data_out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; state=IDLE; rr_last=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RDATA.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata into command registers, and go to ISSUE.
  - If neither req is high, stay in IDLE.
- Arbitration:
  - A single request wins outright.
  - When both requests are high, the winner is the requester that is not rr_last.
  - rr_last updates to the winner on each IDLE->ISSUE transition.
- ISSUE (exactly one cycle):
  - mem_addr and mem_data_in hold the latched values.
  - mem_write_en=we and mem_read=~we.
  - gnt of the winner pulses high.
  - Next state: RDATA if read, IDLE if write.
- RDATA (exactly one cycle):
  - All mem_* strobes are 0.
  - rdata = mem_data_out, registered at the end of ISSUE's read edge (combinational pass-through from Memory_Unit's registered output).
  - rvalid of the winner pulses high.
  - Next state: IDLE.
- Latency and throughput:
  - Write: gnt 2 cycles after req is sampled in IDLE; occupancy 2 cycles (IDLE, ISSUE).
  - Read: rvalid 3 cycles after req is sampled in IDLE; occupancy 3 cycles.
- Request rules:
  - A requester holds req, we, addr and wdata stable until its gnt.
  - After gnt it deasserts req, or re-asserts it with a new command; a held req counts as a new request.
  - Command values are latched in IDLE, so changes after sampling are ignored.
- Mutual exclusion:
  - mem_write_en and mem_read are never high together.
  - gnt0/gnt1 never both high; rvalid0/rvalid1 never both high.
- Simultaneous events:
  - A req arriving during ISSUE/RDATA waits for IDLE; it is never lost while held.
  - If both requesters are continuously requesting, grants strictly alternate.
- Reset mid-operation:
  - Reset during ISSUE or RDATA aborts immediately; no rvalid is produced.
  - mem strobes drop asynchronously to 0.
  - A write already clocked into Memory_Unit is not undone.
- Address handling: no decoding; all ADDR_WIDTH values pass through, including the 0x3F4/0x3F8/0x3FC I/O window.
- Out of scope: Memory_Unit en_0/en_1 (input-port latch enables) are not arbitrated by this block.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- When defined:
  - Requester 0 always wins ties.
  - rr_last register is removed.
  - Requester 1 may starve while req0 is continuously high.
- When undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, ISSUE, RDATA}
  - req_idx_t (1-bit requester index)
  - constants PORT0_ADDR=10'h3F4, PORT1_ADDR=10'h3F8, OUTPORT_ADDR=10'h3FC (used by benches and the loader)
  - ADDR_WIDTH/DATA_WIDTH defaults
- Sub-module mem_arb_rr_pick:
  - Combinational 2-way winner select from req0, req1 and rr_last.
  - Contains the MEM_ARB_FIXED_PRIO_EN branch.

Test Plan:
1. req0 write 0x010/0x11111111, then req0 read 0x010 -> gnt0 2 cycles after sample; rvalid0 with rdata=0x11111111 3 cycles after read sample; gnt1/rvalid1 stay 0.
2. req0 and req1 held high together, reads of 0x040 and 0x080 preloaded 0x22222222/0x33333333 -> grant order 0,1,0,1; each rvalidN carries its own address's data.
3. req1 write 0x3FC/0xAABBCCDD -> mem_write_en pulses one cycle with mem_addr=0x3FC; Memory_Unit output_port=0xAABBCCDD the next cycle.
4. req0 read of 0x0C0, rst_n low during RDATA -> rvalid0 never pulses; all outputs 0; busy=0; state=IDLE after release.
5. MEM_ARB_FIXED_PRIO_EN defined, req0 and req1 held for 6 grants -> gnt0 on all 6, gnt1 never. Undefined -> 3 and 3.
6. Back-to-back: req0 write 0x000/0x12345678 issued while req1 arrives mid-ISSUE -> req1 granted 2 cycles later; mem_write_en/mem_read never both high (assertion).
